// File: rtl/matmul_drain_pkg.sv
// Shared types and sizing for the matmul output drain.
// ROWS/COLS default to 4 unless the build defines them.
`ifndef ROWS
`define ROWS 4
`endif
`ifndef COLS
`define COLS 4
`endif

package matmul_drain_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SNAP,
        STREAM,
        FIN
    } drain_state_t;

    localparam int ROW_IDX_W = $clog2(`ROWS) + 1;

endpackage

// File: rtl/drain_relu_word.sv
// Signed ReLU on one output word: negative values clamp to zero when enabled.
module drain_relu_word #(
    parameter int WORD_SIZE = 16
) (
    input  logic [WORD_SIZE-1:0] word,
    input  logic                 relu_en,
    output logic [WORD_SIZE-1:0] result
);

    assign result = (relu_en && word[WORD_SIZE-1]) ? '0 : word;

endmodule

// File: rtl/matmul_output_drain.sv
// Snapshots the collected matmul result on start, then streams it one row per
// beat over valid/ready, with optional ReLU applied on the way out.
module matmul_output_drain
    import matmul_drain_pkg::*;
#(
    parameter int ROWS      = `ROWS,
    parameter int COLS      = `COLS,
    parameter int WORD_SIZE = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      relu_en,
    input  logic [WORD_SIZE-1:0]      output_matrix [ROWS][COLS],
    input  logic                      out_ready,
    output logic                      out_valid,
    output logic [COLS*WORD_SIZE-1:0] out_data,
    output logic [$clog2(ROWS):0]     out_row,
    output logic                      out_last,
    output logic                      busy,
    output logic                      done,
    output logic                      start_overrun
);

    localparam int            RW       = $clog2(ROWS) + 1;
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

    drain_state_t         state_q, state_d;
    logic [WORD_SIZE-1:0] mat_buf    [ROWS][COLS];
    logic [WORD_SIZE-1:0] row_words  [COLS];
    logic [WORD_SIZE-1:0] relu_words [COLS];
    logic [RW-1:0]        row_q;
    logic                 relu_q;
    logic                 overrun_q;
    logic                 accept_start;
    logic                 at_last;
    logic                 xfer;

    // FIN accepts a new start so back-to-back matmuls lose no cycle.
    assign accept_start  = start && (state_q == IDLE || state_q == FIN);
    assign out_valid     = (state_q == STREAM);
    assign at_last       = (row_q == LAST_ROW);
    assign xfer          = out_valid && out_ready;
    assign busy          = (state_q == SNAP) || (state_q == STREAM);
    assign done          = (state_q == FIN);
    assign out_row       = row_q;
    assign out_last      = out_valid && at_last;
    assign start_overrun = overrun_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            row_q     <= '0;
            relu_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            overrun_q <= start && busy;
            if (accept_start) begin
                row_q  <= '0;
                relu_q <= relu_en;
            end else if (xfer) begin
                row_q <= at_last ? '0 : row_q + 1'b1;
            end
        end
    end

    // NOTE: the snapshot buffer has no reset; it is always rewritten before
    // it is read, and leaving it out keeps it mappable to plain storage.
    always_ff @(posedge clk) begin
        if (accept_start) begin
            mat_buf <= output_matrix;
        end
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SNAP;
            SNAP:    state_d = STREAM;
            STREAM:  if (xfer && at_last) state_d = FIN;
            FIN:     state_d = start ? SNAP : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        row_words = mat_buf[0];
        for (int r = 0; r < ROWS; r++) begin
            if (row_q == RW'(r)) begin
                row_words = mat_buf[r];
            end
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_col
        drain_relu_word #(
            .WORD_SIZE(WORD_SIZE)
        ) u_relu (
            .word   (row_words[c]),
            .relu_en(relu_q),
            .result (relu_words[c])
        );
        assign out_data[c*WORD_SIZE +: WORD_SIZE] = out_valid ? relu_words[c] : '0;
    end

endmodule
